// File: rtl/dma_utils_pkg.sv
// Shared DMA types: AXI read request/response, burst mode, streamer state
// and the 4 KB page constant. The request struct is sized for the widest
// supported configuration (64-bit address, 256-bit data); narrower
// instances zero-extend into it.
package dma_utils_pkg;

  localparam int DMA_AXI_ADDR_W = 64;
  localparam int DMA_AXI_STRB_W = 32;
  localparam int DMA_4KB        = 4096;

  typedef enum logic {
    DMA_MODE_INCR  = 1'b0,
    DMA_MODE_FIXED = 1'b1
  } dma_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_REQ  = 2'd2,
    ST_DONE = 2'd3
  } dma_rd_state_t;

  typedef struct packed {
    logic                      valid;
    logic [DMA_AXI_ADDR_W-1:0] addr;
    logic [7:0]                alen;
    logic [2:0]                size;
    logic [DMA_AXI_STRB_W-1:0] strb;
    dma_mode_t                 mode;
  } s_dma_axi_req_t;

  typedef struct packed {
    logic ready;
  } s_dma_axi_resp_t;

endpackage

// File: rtl/dma_rd_streamer_if.sv
// Read-request channel between the streamer (master) and the DMA AXI
// interface (slave).
interface dma_rd_streamer_if;
  import dma_utils_pkg::*;

  s_dma_axi_req_t  dma_axi_rd_req_o;
  s_dma_axi_resp_t dma_axi_rd_resp_i;

  modport master (output dma_axi_rd_req_o, input dma_axi_rd_resp_i);
  modport slave  (input dma_axi_rd_req_o, output dma_axi_rd_resp_i);

endinterface

// File: rtl/dma_burst_calc.sv
// Combinational burst sizing: given the current address, remaining bytes
// and mode, picks either a single-beat partial burst (unaligned head or
// short tail) or the longest legal full-strobe body burst.
module dma_burst_calc
  import dma_utils_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 256
) (
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic [31:0]               rem,
  input  dma_mode_t                 mode,
  output logic [7:0]                alen,
  output logic [DMA_AXI_STRB_W-1:0] strb,
  output logic [31:0]               nb
);

  localparam int              BPB       = DATA_WIDTH / 8;
  localparam int              SIZE      = $clog2(BPB);
  localparam logic [31:0]     BPB_U     = 32'(BPB);
  localparam logic [63:0]     FULL_MASK = (64'd1 << BPB) - 64'd1;

  logic [31:0] off;
  logic [31:0] head_nb;
  logic [63:0] head_mask;
  logic [31:0] beats;
  logic [31:0] page_beats;

  // Size the next burst; body bursts never cross a 4 KB page in INCR
  always_comb begin
    off        = 32'(addr & ADDR_WIDTH'(BPB - 1));
    page_beats = (32'(DMA_4KB) - (32'(addr) & 32'(DMA_4KB - 1))) >> SIZE;
    head_nb    = BPB_U - off;
    if (rem < head_nb) head_nb = rem;
    head_mask  = ((64'd1 << head_nb) - 64'd1) << off;
    beats      = rem >> SIZE;
    if (mode == DMA_MODE_FIXED) begin
      if (beats > 32'd16) beats = 32'd16;
    end else begin
      if (beats > 32'(MAX_BEATS)) beats = 32'(MAX_BEATS);
      if (beats > page_beats) beats = page_beats;
    end
    alen = '0;
    strb = '0;
    nb   = '0;
    if (off != 32'd0 || rem < BPB_U) begin
      alen = 8'd0;
      strb = DMA_AXI_STRB_W'(head_mask);
      nb   = head_nb;
    end else begin
      alen = 8'(beats - 32'd1);
      strb = DMA_AXI_STRB_W'(FULL_MASK);
      nb   = beats << SIZE;
    end
  end

endmodule

// File: rtl/dma_rd_streamer.sv
// Read-side burst sequencer: splits a descriptor into AXI4 read bursts and
// issues them one at a time. Optional burst counter enabled by the macro
// DMA_RD_STREAMER_STATS_EN (adds output burst_cnt_o).
module dma_rd_streamer
  import dma_utils_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dma_go_i,
  input  logic                  dma_abort_i,
  input  logic [ADDR_WIDTH-1:0] desc_addr_i,
  input  logic [31:0]           desc_bytes_i,
  input  dma_mode_t             desc_mode_i,
  dma_rd_streamer_if.master     axi,
`ifdef DMA_RD_STREAMER_STATS_EN
  output logic [15:0]           burst_cnt_o,
`endif
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int                    SIZE     = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(DATA_WIDTH / 8 - 1);

  dma_rd_state_t             state;
  logic [ADDR_WIDTH-1:0]     cur_addr_ff;
  logic [31:0]               rem_ff;
  dma_mode_t                 mode_ff;
  logic                      abort_ff;
  logic [31:0]               nb_ff;
  logic [ADDR_WIDTH-1:0]     req_addr_ff;
  logic [7:0]                req_alen_ff;
  logic [2:0]                req_size_ff;
  logic [DMA_AXI_STRB_W-1:0] req_strb_ff;
  logic [7:0]                calc_alen;
  logic [DMA_AXI_STRB_W-1:0] calc_strb;
  logic [31:0]               calc_nb;
  logic                      hs;
  s_dma_axi_req_t            req;

  dma_burst_calc #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_BEATS  (MAX_BEATS)
  ) u_calc (
    .addr (cur_addr_ff),
    .rem  (rem_ff),
    .mode (mode_ff),
    .alen (calc_alen),
    .strb (calc_strb),
    .nb   (calc_nb)
  );

  assign hs     = (state == ST_REQ) && axi.dma_axi_rd_resp_i.ready;
  assign busy_o = (state != ST_IDLE);
  assign done_o = (state == ST_DONE);

  // Request bus: valid decoded from state, fields from burst registers
  always_comb begin
    req       = '0;
    req.valid = (state == ST_REQ);
    req.addr  = DMA_AXI_ADDR_W'(req_addr_ff);
    req.alen  = req_alen_ff;
    req.size  = req_size_ff;
    req.strb  = req_strb_ff;
    req.mode  = mode_ff;
  end

  assign axi.dma_axi_rd_req_o = req;

  // Sequencer FSM: latch descriptor, size a burst, hold it until accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cur_addr_ff <= '0;
      rem_ff      <= '0;
      mode_ff     <= DMA_MODE_INCR;
      abort_ff    <= 1'b0;
      nb_ff       <= '0;
      req_addr_ff <= '0;
      req_alen_ff <= '0;
      req_size_ff <= '0;
      req_strb_ff <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          abort_ff <= 1'b0;
          if (dma_go_i) begin
            cur_addr_ff <= desc_addr_i;
            rem_ff      <= desc_bytes_i;
            mode_ff     <= desc_mode_i;
            state       <= (desc_bytes_i == 32'd0) ? ST_DONE : ST_CALC;
          end
        end
        ST_CALC: begin
          if (dma_abort_i) begin
            state <= ST_DONE;
          end else begin
            req_addr_ff <= cur_addr_ff & ~OFF_MASK;
            req_alen_ff <= calc_alen;
            req_size_ff <= 3'(SIZE);
            req_strb_ff <= calc_strb;
            nb_ff       <= calc_nb;
            state       <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (hs) begin
            if (mode_ff == DMA_MODE_INCR) cur_addr_ff <= cur_addr_ff + ADDR_WIDTH'(nb_ff);
            rem_ff <= rem_ff - nb_ff;
            state  <= (rem_ff == nb_ff || abort_ff || dma_abort_i) ? ST_DONE : ST_CALC;
          end else if (dma_abort_i) begin
            abort_ff <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DMA_RD_STREAMER_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Accepted-burst counter, restarted by each accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt_o <= '0;
    end else if (state == ST_IDLE && dma_go_i) begin
      burst_cnt_o <= '0;
    end else if (hs) begin
      burst_cnt_o <= sat_inc16(burst_cnt_o);
    end
  end
`endif

endmodule

// File: tb/tb_dma_rd_streamer.sv
// Randomised bench for dma_rd_streamer (DATA_WIDTH 32, MAX_BEATS 16) with
// a descriptor-level reference model producing the expected burst list.
module tb_dma_rd_streamer;
  import dma_utils_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic        abort;
  logic [31:0] d_addr;
  logic [31:0] d_bytes;
  dma_mode_t   d_mode;
  logic        busy;
  logic        done;
`ifdef DMA_RD_STREAMER_STATS_EN
  logic [15:0] burst_cnt;
`endif

  dma_rd_streamer_if bus ();

  dma_rd_streamer #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MAX_BEATS  (MB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .dma_go_i     (go),
    .dma_abort_i  (abort),
    .desc_addr_i  (d_addr),
    .desc_bytes_i (d_bytes),
    .desc_mode_i  (d_mode),
    .axi          (bus),
`ifdef DMA_RD_STREAMER_STATS_EN
    .burst_cnt_o  (burst_cnt),
`endif
    .busy_o       (busy),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  alen;
    logic [3:0]  strb;
  } burst_t;

  burst_t exp_q[$];
  int     n_tests = 0;
  int     n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected bursts for a descriptor, straight from the splitting rules
  function automatic void model(input logic [31:0] a, input logic [31:0] n, input dma_mode_t m);
    logic [31:0] rem;
    logic [31:0] cur;
    int unsigned off;
    int unsigned take;
    int unsigned beats;
    int unsigned room;
    burst_t      b;
    rem = n;
    cur = a;
    exp_q.delete();
    while (rem != 0) begin
      off = cur % 4;
      if (off != 0 || rem < 4) begin
        take   = (4 - off < rem) ? 4 - off : rem;
        b.alen = 8'd0;
        b.strb = 4'(((1 << take) - 1) << off);
      end else begin
        beats = rem / 4;
        if (beats > 16) beats = 16;
        if (m == DMA_MODE_INCR) begin
          room = (4096 - (cur % 4096)) / 4;
          if (beats > room) beats = room;
        end
        take   = beats * 4;
        b.alen = 8'(beats - 1);
        b.strb = 4'hF;
      end
      b.addr = cur - off;
      exp_q.push_back(b);
      rem = rem - take;
      if (m == DMA_MODE_INCR) cur = cur + take;
    end
  endfunction

  // Runs one descriptor against exp_q; exp_q must already hold the expected bursts
  task automatic run_xfer(input string name, input logic [31:0] a, input logic [31:0] n,
                          input dma_mode_t m, input int rdy_pct, input int hold_cycles,
                          input int abort_idx, input bit mid_go);
    int             cyc      = 0;
    int             hs_cnt   = 0;
    int             last_hs  = -10;
    int             wait_cnt = 0;
    int             held     = 0;
    bit             fin      = 0;
    bit             prev_v   = 0;
    bit             prev_hs  = 0;
    bit             hs_now;
    s_dma_axi_req_t prev_req = '0;
    s_dma_axi_req_t r;
    burst_t         e;
    logic           rdy;

    @(posedge clk); #1;
    go = 1'b1; d_addr = a; d_bytes = n; d_mode = m;
    bus.dma_axi_rd_resp_i.ready = 1'b0;
    while (!fin && cyc < 5000) begin
      @(posedge clk); #1;
      go      = (mid_go && cyc == 3);
      d_addr  = $urandom;
      d_bytes = $urandom_range(1, 64);
      d_mode  = dma_mode_t'($urandom_range(0, 1));
      abort   = 1'b0;
      rdy     = ($urandom_range(0, 99) < rdy_pct);
      if (hs_cnt == 0 && held < hold_cycles) begin
        rdy = 1'b0;
        if (prev_v) held++;
      end
      if (abort_idx >= 0 && hs_cnt == abort_idx && wait_cnt < 3) begin
        rdy = 1'b0;
        if (prev_v && !prev_hs) begin
          abort = (wait_cnt == 1);
          wait_cnt++;
        end
      end
      bus.dma_axi_rd_resp_i.ready = rdy;

      @(negedge clk);
      cyc++;
      r      = bus.dma_axi_rd_req_o;
      hs_now = r.valid && bus.dma_axi_rd_resp_i.ready;
      if (n == 0) check_eq({name, "_zero_len_valid"}, r.valid, 1'b0);
      if (prev_v && !prev_hs) begin
        check_eq({name, "_hold_valid"}, r.valid, 1'b1);
        check_eq({name, "_hold_addr"}, r.addr, prev_req.addr);
        check_eq({name, "_hold_alen"}, r.alen, prev_req.alen);
        check_eq({name, "_hold_strb"}, r.strb, prev_req.strb);
      end
      if (r.valid && !(prev_v && !prev_hs)) begin
        if (hs_cnt == 0) check_eq({name, "_first_valid_cyc"}, cyc, 2);
        else             check_eq({name, "_next_valid_cyc"}, cyc, last_hs + 2);
      end
      if (hs_now) begin
        check_eq({name, "_burst_expected"}, exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq({name, "_addr"}, r.addr, {32'd0, e.addr});
          check_eq({name, "_alen"}, r.alen, e.alen);
          check_eq({name, "_strb"}, r.strb, e.strb);
          check_eq({name, "_size"}, r.size, 3'd2);
          check_eq({name, "_mode"}, r.mode, m);
        end
        hs_cnt++;
        last_hs = cyc;
      end
      if (done) begin
        if (n == 0) check_eq({name, "_zero_len_done_by_2"}, cyc <= 2, 1'b1);
        else        check_eq({name, "_done_cyc"}, cyc, last_hs + 1);
        check_eq({name, "_bursts_left"}, exp_q.size(), 0);
        check_eq({name, "_busy_at_done"}, busy, 1'b1);
`ifdef DMA_RD_STREAMER_STATS_EN
        check_eq({name, "_burst_cnt"}, burst_cnt, hs_cnt);
`endif
        fin = 1'b1;
      end
      prev_v   = r.valid;
      prev_hs  = hs_now;
      prev_req = r;
    end
    check_eq({name, "_finished"}, fin, 1'b1);
    @(posedge clk); #1;
    go = 1'b0; abort = 1'b0; bus.dma_axi_rd_resp_i.ready = 1'b0;
    @(negedge clk);
    check_eq({name, "_idle_busy"}, busy, 1'b0);
    check_eq({name, "_idle_valid"}, bus.dma_axi_rd_req_o.valid, 1'b0);
    exp_q.delete();
  endtask

  initial begin
    bit             seen;
    s_dma_axi_req_t rr;
    rst = 1'b1; go = 1'b0; abort = 1'b0;
    d_addr = '0; d_bytes = '0; d_mode = DMA_MODE_INCR;
    bus.dma_axi_rd_resp_i.ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    rr = bus.dma_axi_rd_req_o;
    check_eq("rst_valid", rr.valid, 1'b0);
    check_eq("rst_addr", rr.addr, 64'd0);
    check_eq("rst_alen", rr.alen, 8'd0);
    check_eq("rst_size", rr.size, 3'd0);
    check_eq("rst_strb", rr.strb, 32'd0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
`ifdef DMA_RD_STREAMER_STATS_EN
    check_eq("rst_burst_cnt", burst_cnt, 16'd0);
`endif

    // Aligned INCR, ready high
    exp_q.push_back('{32'h1000, 8'd15, 4'hF});
    run_xfer("aligned", 32'h1000, 32'd64, DMA_MODE_INCR, 100, 0, -1, 0);

    // Unaligned head and tail
    exp_q.push_back('{32'h1000, 8'd0, 4'hE});
    exp_q.push_back('{32'h1004, 8'd0, 4'hF});
    exp_q.push_back('{32'h1008, 8'd0, 4'h7});
    run_xfer("unaligned", 32'h1001, 32'd10, DMA_MODE_INCR, 100, 0, -1, 0);

    // 4 KB crossing
    exp_q.push_back('{32'h0FF0, 8'd3, 4'hF});
    exp_q.push_back('{32'h1000, 8'd11, 4'hF});
    run_xfer("cross4k", 32'h0FF0, 32'd64, DMA_MODE_INCR, 100, 0, -1, 0);

    // Sub-word transfer
    exp_q.push_back('{32'h2000, 8'd0, 4'h6});
    run_xfer("subword", 32'h2001, 32'd2, DMA_MODE_INCR, 100, 0, -1, 0);

    // Backpressure on the first burst
    model(32'h3000, 32'd32, DMA_MODE_INCR);
    run_xfer("backpressure", 32'h3000, 32'd32, DMA_MODE_INCR, 100, 5, -1, 0);

    // Abort while the second burst waits; only two bursts go out
    exp_q.push_back('{32'h0000, 8'd15, 4'hF});
    exp_q.push_back('{32'h0040, 8'd15, 4'hF});
    run_xfer("abort", 32'h0, 32'd1024, DMA_MODE_INCR, 100, 0, 1, 0);

    // Zero length
    run_xfer("zero_len", 32'h4000, 32'd0, DMA_MODE_INCR, 100, 0, -1, 0);

    // Start pulse while busy is ignored
    model(32'h0500, 32'd40, DMA_MODE_INCR);
    run_xfer("go_busy", 32'h0500, 32'd40, DMA_MODE_INCR, 50, 0, -1, 1);

    // FIXED mode capped at 16 beats, address not advancing
    exp_q.push_back('{32'h0100, 8'd15, 4'hF});
    exp_q.push_back('{32'h0100, 8'd3, 4'hF});
    run_xfer("fixed", 32'h0100, 32'd80, DMA_MODE_FIXED, 70, 0, -1, 0);

    // Address wrap at the top of the address space
    model(32'hFFFF_FFFE, 32'd8, DMA_MODE_INCR);
    run_xfer("wrap", 32'hFFFF_FFFE, 32'd8, DMA_MODE_INCR, 80, 0, -1, 0);

    // Randomised descriptors
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      logic [31:0] n;
      dma_mode_t   m;
      a = ($urandom_range(0, 3) == 0) ? (32'h0000_0FC0 + 32'($urandom_range(0, 80))) : $urandom;
      n = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : 32'($urandom_range(1, 300));
      m = dma_mode_t'($urandom_range(0, 1));
      model(a, n, m);
      run_xfer("random", a, n, m, $urandom_range(30, 100), 0, -1, 0);
    end

    // Reset in the middle of a held request drops valid
    @(posedge clk); #1;
    go = 1'b1; d_addr = 32'h800; d_bytes = 32'd64; d_mode = DMA_MODE_INCR;
    bus.dma_axi_rd_resp_i.ready = 1'b0;
    @(posedge clk); #1;
    go = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = bus.dma_axi_rd_req_o.valid;
    end
    check_eq("midrst_valid_seen", seen, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_valid", bus.dma_axi_rd_req_o.valid, 1'b0);
    check_eq("midrst_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
